frag_send_sched: RTL and testbench
==================================

Name: frag_send_sched

Overview:
- Scheduler in front of the 4-lane packet fragmenter.
- Round-robin arbitrates N lane requesters for the single fragmenter. For the granted lane it loads the packet, fires the start strobe and waits for fragmentation done.
- It then waits for the matching ACK and retransmits on timeout, up to a retry limit.
- Maintains a 1-bit alternating sequence number per lane.

Parameters:
- N_LANES, 4, number of requesting lanes (power of 2, ≥2)
- PKT_WIDTH, 1041, width of the encapsulated packet handed to the fragmenter
- LANE_W, 2, log2(N_LANES)
- TIMER_WIDTH, 12, width of the ACK/watchdog timer
- ACK_TIMEOUT, 1024, cycles to wait for an ACK after fragmentation done
- MAX_RETRY, 3, retransmissions allowed before a lane is failed
- FRAG_TIMEOUT, 64, watchdog limit (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- lane_req  in  N_LANES  per-lane send request; level, held until done/fail
- lane_pkt  in  N_LANES*PKT_WIDTH  lane i packet at bits [i*PKT_WIDTH +: PKT_WIDTH]
- lane_grant  out  N_LANES  one-hot owner of the fragmenter; 0 when idle
- lane_done  out  N_LANES  1-cycle pulse: packet ACKed
- lane_fail  out  N_LANES  1-cycle pulse: retries exhausted or watchdog abort
- lane_seq  out  N_LANES  expected sequence bit per lane; requester embeds it in its packet
- valid_pkt_send  out  1  1-cycle load strobe to the fragmenter
- pkt_data  out  PKT_WIDTH  muxed packet of the granted lane
- start_fragment_pkt  out  1  1-cycle start strobe to the fragmenter
- frag_pkt_done  in  1  fragmenter completion pulse
- ack_valid  in  1  ACK received
- ack_lane  in  LANE_W  lane the ACK belongs to
- ack_seq  in  1  sequence bit carried by the ACK
- busy  out  1  high in every state except IDLE
- frag_err  out  1  sticky watchdog flag (optional feature only; else tied 0)

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to 0:
  - every output
  - rr_ptr, lane_seq, the timer and retry_cnt
  - state goes to IDLE
- Reset mid-transaction abandons the transaction; no done/fail pulse is produced.
- FSM states: IDLE, LOAD, START, FRAG, WAIT_ACK, FIN.
- IDLE:
  - If any lane_req is high, pick the first set bit at or after rr_ptr, cyclically, and latch it as cur.
  - Next state LOAD; lane_grant[cur] rises in the same cycle as the move to LOAD.
- LOAD:
  - valid_pkt_send=1; pkt_data = lane_pkt slice for cur; retry_cnt=0.
  - Next state START.
- START:
  - start_fragment_pkt=1 for exactly one cycle.
  - The strobe is always preceded and followed by ≥1 low cycle, which guarantees the fragmenter sees a clean rising edge.
  - Next state FRAG.
- FRAG:
  - Wait for frag_pkt_done.
  - On frag_pkt_done: timer=ACK_TIMEOUT-1, next state WAIT_ACK.
  - ACKs arriving in FRAG are ignored.
- WAIT_ACK:
  - The timer decrements each cycle.
  - ACK match means ack_valid && ack_lane==cur && ack_seq==lane_seq[cur]. On a match: lane_done[cur]=1 (registered), toggle lane_seq[cur], go to FIN.
  - A non-matching ACK (wrong lane or stale seq) is dropped.
  - Timer reaches 0 with no match:
    - If retry_cnt<MAX_RETRY: retry_cnt++ and go to START. No reload is needed because the fragmenter retains the packet.
    - Otherwise: lane_fail[cur]=1 and go to FIN; lane_seq is not toggled.
  - A match in the same cycle as expiry counts as success.
- FIN:
  - lane_grant=0; rr_ptr=cur+1 (mod N_LANES).
  - Next state IDLE.
  - Minimum grant-to-grant gap is 2 cycles.
- Request handling:
  - Deasserting lane_req mid-transaction does not abort it.
  - The requester must drop lane_req the cycle after it sees lane_done/lane_fail; otherwise the lane re-arbitrates.
  - pkt_data holds its last value outside LOAD.
- ACK latency window: the last retransmission fails at FRAG-done + ACK_TIMEOUT cycles.

Optional Feature:
- Macro: FRAG_WATCHDOG_EN.
- Defined:
  - On entry to FRAG the timer is loaded with FRAG_TIMEOUT-1.
  - If frag_pkt_done does not arrive before the timer reaches 0: lane_fail[cur] pulses, frag_err is set (sticky until rst), next state FIN.
- Undefined: FRAG waits indefinitely; frag_err is tied 0.

Decomposition:
- Shared package frag_pkg holds:
  - state encoding constants IDLE..FIN
  - PKT_WIDTH and LANE_W defaults
  - ACK_TIMEOUT and MAX_RETRY defaults
- One natural sub-module: rr_arbiter (N_LANES req, rr_ptr in → one-hot grant and encoded index, purely combinational). It is reusable by the receive side.

Test Plan:
- Single lane: lane_req=4'b0001, frag_pkt_done 5 cycles after start, then ACK lane0 seq0 3 cycles later → the following are expected:
  - valid_pkt_send one cycle after grant, start_fragment_pkt the cycle after that
  - lane_done[0] pulse, lane_seq[0]=1
- Round-robin: lane_req=4'b1111 held, every packet ACKed → grant order 0,1,2,3,0.
- Timeout/retry: ACK_TIMEOUT=16, never ACK → 4 start strobes in total, then lane_fail[0]; lane_seq[0] unchanged.
- Stale/wrong ACK: during WAIT_ACK send ACK lane1, then ACK lane0 seq1 → both dropped; then ACK lane0 seq0 → lane_done[0].
- Simultaneous: matching ACK on the exact cycle the timer hits 0 → lane_done, no retransmit.
- rst pulse while in WAIT_ACK → all outputs 0 and IDLE within the same cycle; no done/fail pulse. With FRAG_WATCHDOG_EN and frag_pkt_done withheld for 64 cycles → lane_fail, frag_err=1.

Source files
------------

// File: rtl/frag_pkg.sv
// Shared definitions for the fragmenter schedulers: FSM state encoding and
// default sizing/timing constants.
package frag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        FRAG,
        WAIT_ACK,
        FIN
    } frag_state_t;

    localparam int DEF_N_LANES     = 4;
    localparam int DEF_PKT_WIDTH   = 1041;
    localparam int DEF_LANE_W      = 2;
    localparam int DEF_TIMER_WIDTH = 12;
    localparam int DEF_ACK_TIMEOUT = 1024;
    localparam int DEF_MAX_RETRY   = 3;

endpackage

// File: rtl/frag_send_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after rr_ptr,
// searched cyclically. Shared by the send and receive schedulers.
module rr_arbiter #(
    parameter int N_LANES = 4,
    parameter int LANE_W  = 2
) (
    input  logic [N_LANES-1:0] req,
    input  logic [LANE_W-1:0]  rr_ptr,
    output logic [N_LANES-1:0] grant,
    output logic [LANE_W-1:0]  grant_idx,
    output logic               any_req
);

    logic [LANE_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_LANES; i++) begin
            // Wraps naturally because N_LANES is a power of two.
            cand = rr_ptr + LANE_W'(i);
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/frag_send_sched.sv
// Send-side scheduler: round-robin lane arbitration, fragmenter load/start
// handshake, ACK wait with timeout retransmission. FRAG_WATCHDOG_EN adds a
// fragmentation watchdog that fails the lane and sets sticky frag_err.
module frag_send_sched
    import frag_pkg::*;
#(
    parameter int N_LANES     = DEF_N_LANES,
    parameter int PKT_WIDTH   = DEF_PKT_WIDTH,
    parameter int LANE_W      = DEF_LANE_W,
    parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
`ifdef FRAG_WATCHDOG_EN
    ,
    parameter int FRAG_TIMEOUT = 64
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_LANES-1:0]           lane_req,
    input  logic [N_LANES*PKT_WIDTH-1:0] lane_pkt,
    output logic [N_LANES-1:0]           lane_grant,
    output logic [N_LANES-1:0]           lane_done,
    output logic [N_LANES-1:0]           lane_fail,
    output logic [N_LANES-1:0]           lane_seq,
    output logic                         valid_pkt_send,
    output logic [PKT_WIDTH-1:0]         pkt_data,
    output logic                         start_fragment_pkt,
    input  logic                         frag_pkt_done,
    input  logic                         ack_valid,
    input  logic [LANE_W-1:0]            ack_lane,
    input  logic                         ack_seq,
    output logic                         busy,
    output logic                         frag_err
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [TIMER_WIDTH-1:0] ACK_LOAD = TIMER_WIDTH'(ACK_TIMEOUT - 1);

    frag_state_t            state_q, state_d;
    logic [LANE_W-1:0]      cur_q, cur_d, rr_q, rr_d;
    logic [N_LANES-1:0]     grant_q, grant_d, done_q, done_d, fail_q, fail_d, seq_q, seq_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   vps_q, vps_d, sfp_q, sfp_d;
    logic [PKT_WIDTH-1:0]   pkt_q;
    logic [N_LANES-1:0]     arb_grant, cur_onehot;
    logic [LANE_W-1:0]      arb_idx;
    logic                   arb_any, ack_match;
`ifdef FRAG_WATCHDOG_EN
    localparam logic [TIMER_WIDTH-1:0] WD_LOAD = TIMER_WIDTH'(FRAG_TIMEOUT - 1);
    logic                   err_q, err_d;
`endif

    rr_arbiter #(
        .N_LANES (N_LANES),
        .LANE_W  (LANE_W)
    ) u_arb (
        .req       (lane_req),
        .rr_ptr    (rr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    assign cur_onehot = N_LANES'(1) << cur_q;
    assign ack_match  = ack_valid && (ack_lane == cur_q) && (ack_seq == seq_q[cur_q]);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        seq_d   = seq_q;
        timer_d = timer_q;
        retry_d = retry_q;
        done_d  = '0;
        fail_d  = '0;
        vps_d   = 1'b0;
        sfp_d   = 1'b0;
`ifdef FRAG_WATCHDOG_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    cur_d   = arb_idx;
                    grant_d = arb_grant;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                vps_d   = 1'b1;
                retry_d = '0;
                state_d = START;
            end
            // Registered strobe: the LOAD/START cycles and the cycle after keep it isolated.
            START: begin
                sfp_d   = 1'b1;
                state_d = FRAG;
`ifdef FRAG_WATCHDOG_EN
                timer_d = WD_LOAD;
`endif
            end
            FRAG: begin
                if (frag_pkt_done) begin
                    timer_d = ACK_LOAD;
                    state_d = WAIT_ACK;
                end
`ifdef FRAG_WATCHDOG_EN
                else if (timer_q == '0) begin
                    fail_d  = cur_onehot;
                    grant_d = '0;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
`endif
            end
            WAIT_ACK: begin
                // A match wins over a simultaneous expiry.
                if (ack_match) begin
                    done_d        = cur_onehot;
                    seq_d[cur_q]  = ~seq_q[cur_q];
                    grant_d       = '0;
                    state_d       = FIN;
                end else if (timer_q == '0) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = START;
                    end else begin
                        fail_d  = cur_onehot;
                        grant_d = '0;
                        state_d = FIN;
                    end
                end else begin
                    timer_d = timer_q - TIMER_WIDTH'(1);
                end
            end
            FIN: begin
                rr_d    = cur_q + LANE_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            seq_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            done_q  <= '0;
            fail_q  <= '0;
            vps_q   <= 1'b0;
            sfp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            seq_q   <= seq_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            vps_q   <= vps_d;
            sfp_q   <= sfp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q <= '0;
        end else if (state_q == LOAD) begin
            pkt_q <= lane_pkt[cur_q*PKT_WIDTH +: PKT_WIDTH];
        end
    end

`ifdef FRAG_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign frag_err = err_q;
`else
    assign frag_err = 1'b0;
`endif

    assign lane_grant         = grant_q;
    assign lane_done          = done_q;
    assign lane_fail          = fail_q;
    assign lane_seq           = seq_q;
    assign valid_pkt_send     = vps_q;
    assign pkt_data           = pkt_q;
    assign start_fragment_pkt = sfp_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_frag_send_sched.sv
// Scoreboard bench for frag_send_sched: expected loads and done/fail events are
// queued as stimulus is driven and matched by a negedge monitor.
module tb_frag_send_sched;

    localparam int N  = 4;
    localparam int PW = 1041;
    localparam int LW = 2;
    localparam int TW = 12;
    localparam int AT = 16;
    localparam int MR = 3;

    logic            clk, rst;
    logic [N-1:0]    lane_req;
    logic [N*PW-1:0] lane_pkt;
    logic [N-1:0]    lane_grant, lane_done, lane_fail, lane_seq;
    logic            valid_pkt_send, start_fragment_pkt, frag_pkt_done;
    logic [PW-1:0]   pkt_data;
    logic            ack_valid, ack_seq, busy, frag_err;
    logic [LW-1:0]   ack_lane;

    int n_total = 0;
    int n_pass  = 0;
    int start_cnt = 0;
    logic [N-1:0] exp_seq;

    typedef struct { int lane; logic [PW-1:0] pkt; } pkt_exp_t;
    typedef struct { int lane; bit is_fail; } evt_exp_t;
    pkt_exp_t exp_pkt_q[$];
    evt_exp_t exp_evt_q[$];
    pkt_exp_t mon_pe;
    evt_exp_t mon_ee;
    logic [N-1:0] mon_d, mon_f;

    frag_send_sched #(
        .N_LANES     (N),
        .PKT_WIDTH   (PW),
        .LANE_W      (LW),
        .TIMER_WIDTH (TW),
        .ACK_TIMEOUT (AT),
        .MAX_RETRY   (MR)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lane_req           (lane_req),
        .lane_pkt           (lane_pkt),
        .lane_grant         (lane_grant),
        .lane_done          (lane_done),
        .lane_fail          (lane_fail),
        .lane_seq           (lane_seq),
        .valid_pkt_send     (valid_pkt_send),
        .pkt_data           (pkt_data),
        .start_fragment_pkt (start_fragment_pkt),
        .frag_pkt_done      (frag_pkt_done),
        .ack_valid          (ack_valid),
        .ack_lane           (ack_lane),
        .ack_seq            (ack_seq),
        .busy               (busy),
        .frag_err           (frag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    function automatic logic [N-1:0] onehot(input int l);
        return N'(1) << l;
    endfunction

    function automatic int lane_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g === onehot(i)) return i;
        return -1;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (start_fragment_pkt) start_cnt++;
            if (valid_pkt_send) begin
                n_total++;
                if (exp_pkt_q.size() == 0) begin
                    $display("FAIL load_unexpected: got load with grant=%b, required none", lane_grant);
                end else begin
                    mon_pe = exp_pkt_q.pop_front();
                    if (lane_grant !== onehot(mon_pe.lane) || pkt_data !== mon_pe.pkt)
                        $display("FAIL load_pkt: got grant=%b data[63:0]=%h, required grant=%b data[63:0]=%h",
                                 lane_grant, pkt_data[63:0], onehot(mon_pe.lane), mon_pe.pkt[63:0]);
                    else
                        n_pass++;
                end
            end
            if ((|lane_done) || (|lane_fail)) begin
                n_total++;
                if (exp_evt_q.size() == 0) begin
                    $display("FAIL evt_unexpected: got done=%b fail=%b, required none", lane_done, lane_fail);
                end else begin
                    mon_ee = exp_evt_q.pop_front();
                    mon_d  = mon_ee.is_fail ? '0 : onehot(mon_ee.lane);
                    mon_f  = mon_ee.is_fail ? onehot(mon_ee.lane) : '0;
                    if (lane_done !== mon_d || lane_fail !== mon_f)
                        $display("FAIL evt: got done=%b fail=%b, required done=%b fail=%b",
                                 lane_done, lane_fail, mon_d, mon_f);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_seq = '0;
    endtask

    task automatic pulse_done();
        frag_pkt_done = 1'b1;
        tick();
        frag_pkt_done = 1'b0;
    endtask

    task automatic send_ack(input int lane, input logic seq);
        ack_valid = 1'b1;
        ack_lane  = LW'(lane);
        ack_seq   = seq;
        tick();
        ack_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (start_fragment_pkt) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_evt(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 200; i++) begin
            if ((|lane_done) || (|lane_fail)) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic push_pkt(input int lane);
        pkt_exp_t p;
        p.lane = lane;
        p.pkt  = lane_pkt[lane*PW +: PW];
        exp_pkt_q.push_back(p);
    endtask

    task automatic push_evt(input int lane, input bit is_fail);
        evt_exp_t e;
        e.lane    = lane;
        e.is_fail = is_fail;
        exp_evt_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if ({lane_grant, lane_done, lane_fail, lane_seq, valid_pkt_send, start_fragment_pkt, busy, frag_err} !== '0
            || pkt_data !== '0)
            $display("FAIL reset_outputs: got grant=%b done=%b fail=%b seq=%b vps=%b sfp=%b busy=%b err=%b, required all 0",
                     lane_grant, lane_done, lane_fail, lane_seq, valid_pkt_send, start_fragment_pkt, busy, frag_err);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b0 || lane_grant !== '0)
            $display("FAIL reset_idle: got busy=%b grant=%b, required 0/0", busy, lane_grant);
        else n_pass++;
        exp_seq = '0;
    endtask

    task automatic test_single_lane();
        push_pkt(0);
        lane_req = 4'b0001;
        tick();
        n_total++;
        if (lane_grant !== 4'b0001 || valid_pkt_send !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_grant: got grant=%b vps=%b busy=%b, required 0001/0/1", lane_grant, valid_pkt_send, busy);
        else n_pass++;
        tick();
        n_total++;
        if (valid_pkt_send !== 1'b1 || start_fragment_pkt !== 1'b0)
            $display("FAIL single_load: got vps=%b sfp=%b, required 1/0", valid_pkt_send, start_fragment_pkt);
        else n_pass++;
        tick();
        n_total++;
        if (start_fragment_pkt !== 1'b1 || valid_pkt_send !== 1'b0)
            $display("FAIL single_start: got sfp=%b vps=%b, required 1/0", start_fragment_pkt, valid_pkt_send);
        else n_pass++;
        tick();
        n_total++;
        if (start_fragment_pkt !== 1'b0)
            $display("FAIL single_start_width: got sfp=%b, required 0", start_fragment_pkt);
        else n_pass++;
        repeat (3) tick();
        pulse_done();
        tick();
        tick();
        push_evt(0, 1'b0);
        send_ack(0, 1'b0);
        lane_req = '0;
        exp_seq[0] = 1'b1;
        n_total++;
        if (lane_done !== 4'b0001 || lane_seq !== 4'b0001 || lane_grant !== '0 || lane_fail !== '0)
            $display("FAIL single_done: got done=%b seq=%b grant=%b fail=%b, required 0001/0001/0000/0000",
                     lane_done, lane_seq, lane_grant, lane_fail);
        else n_pass++;
        tick();
        n_total++;
        if (lane_done !== '0 || busy !== 1'b0)
            $display("FAIL single_fin: got done=%b busy=%b, required 0000/0", lane_done, busy);
        else n_pass++;
        tick();
        n_total++;
        if (lane_grant !== '0)
            $display("FAIL single_no_rearb: got grant=%b, required 0000", lane_grant);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int lane;
        do_reset();
        for (int k = 0; k < 5; k++) push_pkt(k % N);
        lane_req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_start(ok);
            lane = lane_of(lane_grant);
            n_total++;
            if (!ok || lane != k % N)
                $display("FAIL rr_order[%0d]: got lane %0d (started=%0d), required lane %0d", k, lane, ok, k % N);
            else n_pass++;
            pulse_done();
            push_evt(k % N, 1'b0);
            send_ack(k % N, exp_seq[k % N]);
            exp_seq[k % N] = ~exp_seq[k % N];
            if (k == 4) lane_req = '0;
            n_total++;
            if (lane_done !== onehot(k % N))
                $display("FAIL rr_done[%0d]: got done=%b, required %b", k, lane_done, onehot(k % N));
            else n_pass++;
        end
        repeat (4) tick();
        n_total++;
        if (lane_seq !== exp_seq || busy !== 1'b0)
            $display("FAIL rr_seq: got seq=%b busy=%b, required %b/0", lane_seq, busy, exp_seq);
        else n_pass++;
    endtask

    task automatic test_timeout_retry();
        bit ok;
        int n, s0;
        s0 = start_cnt;
        push_pkt(0);
        push_evt(0, 1'b1);
        lane_req = 4'b0001;
        for (int r = 0; r <= MR; r++) begin
            wait_start(ok);
            pulse_done();
        end
        wait_evt(ok, n);
        lane_req = '0;
        n_total++;
        if (!ok || n != AT)
            $display("FAIL retry_fail_latency: got %0d cycles (seen=%0d), required %0d", n, ok, AT);
        else n_pass++;
        n_total++;
        if (lane_seq !== exp_seq)
            $display("FAIL retry_seq: got seq=%b, required %b", lane_seq, exp_seq);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (start_cnt - s0 != MR + 1 || busy !== 1'b0)
            $display("FAIL retry_starts: got %0d strobes busy=%b, required %0d/0", start_cnt - s0, busy, MR + 1);
        else n_pass++;
    endtask

    task automatic test_stale_ack();
        bit ok;
        push_pkt(0);
        lane_req = 4'b0001;
        wait_start(ok);
        send_ack(0, exp_seq[0]);
        n_total++;
        if (!ok || busy !== 1'b1 || lane_done !== '0)
            $display("FAIL ack_in_frag: got busy=%b done=%b (started=%0d), required 1/0000", busy, lane_done, ok);
        else n_pass++;
        pulse_done();
        send_ack(1, exp_seq[0]);
        send_ack(0, ~exp_seq[0]);
        tick();
        n_total++;
        if (busy !== 1'b1 || lane_done !== '0)
            $display("FAIL wrong_ack: got busy=%b done=%b, required 1/0000", busy, lane_done);
        else n_pass++;
        push_evt(0, 1'b0);
        send_ack(0, exp_seq[0]);
        lane_req = '0;
        exp_seq[0] = ~exp_seq[0];
        n_total++;
        if (lane_done !== 4'b0001)
            $display("FAIL good_ack: got done=%b, required 0001", lane_done);
        else n_pass++;
        tick();
        n_total++;
        if (lane_seq !== exp_seq)
            $display("FAIL stale_seq: got seq=%b, required %b", lane_seq, exp_seq);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        push_pkt(0);
        lane_req = 4'b0001;
        wait_start(ok);
        pulse_done();
        repeat (3) tick();
        n_total++;
        if (busy !== 1'b1 || lane_grant !== 4'b0001)
            $display("FAIL mid_pre: got busy=%b grant=%b, required 1/0001", busy, lane_grant);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({lane_grant, lane_done, lane_fail, lane_seq, valid_pkt_send, start_fragment_pkt, busy, frag_err} !== '0
            || pkt_data !== '0)
            $display("FAIL mid_reset: got grant=%b done=%b fail=%b seq=%b vps=%b sfp=%b busy=%b, required all 0",
                     lane_grant, lane_done, lane_fail, lane_seq, valid_pkt_send, start_fragment_pkt, busy);
        else n_pass++;
        lane_req = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_seq = '0;
        repeat (5) tick();
        n_total++;
        if (busy !== 1'b0 || lane_grant !== '0)
            $display("FAIL mid_after: got busy=%b grant=%b, required 0/0000", busy, lane_grant);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit ok;
        int s0;
        push_pkt(0);
        push_evt(0, 1'b0);
        lane_req = 4'b0001;
        wait_start(ok);
        pulse_done();
        s0 = start_cnt;
        repeat (AT - 1) tick();
        send_ack(0, exp_seq[0]);
        lane_req = '0;
        exp_seq[0] = ~exp_seq[0];
        n_total++;
        if (!ok || lane_done !== 4'b0001 || lane_fail !== '0)
            $display("FAIL simul_done: got done=%b fail=%b (started=%0d), required 0001/0000", lane_done, lane_fail, ok);
        else n_pass++;
        repeat (6) tick();
        n_total++;
        if (start_cnt != s0 || busy !== 1'b0 || lane_seq !== exp_seq)
            $display("FAIL simul_noretx: got strobes=%0d busy=%b seq=%b, required 0/0/%b",
                     start_cnt - s0, busy, lane_seq, exp_seq);
        else n_pass++;
    endtask

    task automatic test_watchdog();
`ifdef FRAG_WATCHDOG_EN
        bit ok, ok2;
        int n;
        push_pkt(0);
        push_evt(0, 1'b1);
        lane_req = 4'b0001;
        wait_start(ok);
        wait_evt(ok2, n);
        lane_req = '0;
        n_total++;
        if (!ok || !ok2 || n != 64 || frag_err !== 1'b1)
            $display("FAIL watchdog: got %0d cycles err=%b, required 64/1", n, frag_err);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (frag_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL watchdog_sticky: got err=%b busy=%b, required 1/0", frag_err, busy);
        else n_pass++;
`else
        n_total++;
        if (frag_err !== 1'b0)
            $display("FAIL frag_err_tied: got %b, required 0", frag_err);
        else n_pass++;
`endif
    endtask

    task automatic test_drain();
        n_total++;
        if (exp_pkt_q.size() != 0 || exp_evt_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d loads %0d events pending, required 0/0",
                     exp_pkt_q.size(), exp_evt_q.size());
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        lane_req      = '0;
        frag_pkt_done = 1'b0;
        ack_valid     = 1'b0;
        ack_lane      = '0;
        ack_seq       = 1'b0;
        exp_seq       = '0;
        for (int b = 0; b < N * PW; b++) lane_pkt[b] = 1'($urandom_range(0, 1));
        test_reset();
        test_single_lane();
        test_round_robin();
        test_timeout_retry();
        test_stale_ack();
        test_reset_mid();
        test_simultaneous();
        test_watchdog();
        tick();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
